// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: command/state encodings, the
// multiply/divide engine selector and the error-flag convention.
package alu_pkg;

    localparam int CMD_W = 4;

    // Command opcodes; encodings 6..15 are invalid.
    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_MUL = 4'd3,
        CMD_DIV = 4'd4,
        CMD_MOD = 4'd5
    } cmd_t;

    // Handshake FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Iterative engine mode: shift-add multiply or restoring divide.
    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_op_t;

    // Every error class folds onto the single error output bit.
    localparam logic ERR_NONE    = 1'b0;
    localparam logic ERR_INVALID = 1'b1;
    localparam logic ERR_DIV0    = 1'b1;
    localparam logic ERR_OVF     = 1'b1;

    // Selects the engine mode for a raw command (div and mod share the divider).
    function automatic md_op_t md_op_of(input logic [CMD_W-1:0] cmd);
        md_op_t op_v;
        case (cmd)
            CMD_DIV: op_v = MD_DIV;
            CMD_MOD: op_v = MD_DIV;
            default: op_v = MD_MUL;
        endcase
        return op_v;
    endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned multiply / restoring divide engine. One iteration per
// step; a single WIDTH+1-bit adder (plus carry) serves both modes.
// Multiply: acc holds the running high half, quo shifts out B and shifts in
// product low bits. Divide: acc is the partial remainder, quo collects
// quotient bits while shifting out the dividend.
module seq_muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  md_op_t           op,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             fin,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] quo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_op_t           op_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [CNT_W-1:0] cnt_r;
    logic             fin_r;

    logic [WIDTH:0]   x_s;
    logic [WIDTH:0]   y_s;
    logic             cin_s;
    logic [WIDTH+1:0] sum_s;
    logic [WIDTH-1:0] acc_n_s;
    logic [WIDTH-1:0] quo_n_s;

    // Shared adder operands and next-iteration values for the selected mode.
    always_comb begin
        x_s     = {(WIDTH+1){1'b0}};
        y_s     = {(WIDTH+1){1'b0}};
        cin_s   = 1'b0;
        acc_n_s = acc_r;
        quo_n_s = quo_r;
        case (op_r)
            MD_MUL: begin
                x_s   = {1'b0, acc_r};
                if (quo_r[0]) begin
                    y_s = {1'b0, opa_r};
                end else begin
                    y_s = {(WIDTH+1){1'b0}};
                end
                cin_s = 1'b0;
            end
            MD_DIV: begin
                x_s   = {acc_r, quo_r[WIDTH-1]};
                y_s   = ~{1'b0, opb_r};
                cin_s = 1'b1;
            end
            default: begin
                x_s   = {(WIDTH+1){1'b0}};
                y_s   = {(WIDTH+1){1'b0}};
                cin_s = 1'b0;
            end
        endcase

        sum_s = {1'b0, x_s} + {1'b0, y_s} + {{(WIDTH+1){1'b0}}, cin_s};

        case (op_r)
            MD_MUL: begin
                acc_n_s = sum_s[WIDTH:1];
                quo_n_s = {sum_s[0], quo_r[WIDTH-1:1]};
            end
            MD_DIV: begin
                // Carry out set means the shifted remainder was >= B: keep the difference.
                if (sum_s[WIDTH+1]) begin
                    acc_n_s = sum_s[WIDTH-1:0];
                    quo_n_s = {quo_r[WIDTH-2:0], 1'b1};
                end else begin
                    acc_n_s = x_s[WIDTH-1:0];
                    quo_n_s = {quo_r[WIDTH-2:0], 1'b0};
                end
            end
            default: begin
                acc_n_s = acc_r;
                quo_n_s = quo_r;
            end
        endcase
    end

    // Engine registers: cleared by reset, seeded on load, advanced on step.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r  <= MD_MUL;
            acc_r <= {WIDTH{1'b0}};
            quo_r <= {WIDTH{1'b0}};
            opa_r <= {WIDTH{1'b0}};
            opb_r <= {WIDTH{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            fin_r <= 1'b0;
        end else if (load) begin
            op_r  <= op;
            acc_r <= {WIDTH{1'b0}};
            quo_r <= (op == MD_DIV) ? a : b;
            opa_r <= a;
            opb_r <= b;
            cnt_r <= {CNT_W{1'b0}};
            fin_r <= 1'b0;
        end else if (step && !fin_r) begin
            acc_r <= acc_n_s;
            quo_r <= quo_n_s;
            // The counter parks on the last index; fin marks completion.
            if (cnt_r == LAST_CNT) begin
                fin_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign fin = fin_r;
    assign acc = acc_r;
    assign quo = quo_r;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: start/busy/done handshake, single-cycle add/sub, and an
// iterative engine for unsigned mul/div/mod. Result and error are registered
// and change only on the completion edge.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         command,
    input  logic [WIDTH-1:0]   input_a,
    input  logic [WIDTH-1:0]   input_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               error
);

    state_t             state_r;
    state_t             state_n_s;
    cmd_t               cmd_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               busy_r;
    logic               done_r;
    logic [2*WIDTH-1:0] result_r;
    logic               error_r;

    logic               accept_s;
    logic               complete_s;
    logic               step_s;
    logic [2*WIDTH-1:0] result_n_s;
    logic               error_n_s;
    logic               b_zero_s;
    logic [WIDTH-1:0]   b_eff_s;
    logic [WIDTH-1:0]   addsum_s;
    logic               ovf_s;
    logic               fin_s;
    logic [WIDTH-1:0]   acc_s;
    logic [WIDTH-1:0]   quo_s;

    // Single-cycle add/sub datapath; sub is A + ~B + 1 on the same adder.
    always_comb begin
        if (cmd_r == CMD_SUB) begin
            b_eff_s = ~b_r;
        end else begin
            b_eff_s = b_r;
        end
        addsum_s = a_r + b_eff_s + {{(WIDTH-1){1'b0}}, (cmd_r == CMD_SUB)};
        // Same-sign operands giving an opposite-sign sum is signed overflow.
        ovf_s    = (a_r[WIDTH-1] == b_eff_s[WIDTH-1]) && (addsum_s[WIDTH-1] != a_r[WIDTH-1]);
        b_zero_s = (b_r == {WIDTH{1'b0}});
    end

    // Handshake FSM next state, engine stepping and completion values.
    always_comb begin
        state_n_s  = state_r;
        accept_s   = 1'b0;
        complete_s = 1'b0;
        step_s     = 1'b0;
        result_n_s = result_r;
        error_n_s  = error_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s  = 1'b1;
                    state_n_s = ST_RUN;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                case (cmd_r)
                    CMD_NOP: begin
                        complete_s = 1'b1;
                        result_n_s = {(2*WIDTH){1'b0}};
                        error_n_s  = ERR_NONE;
                    end
                    CMD_ADD, CMD_SUB: begin
                        complete_s = 1'b1;
                        result_n_s = {{WIDTH{1'b0}}, addsum_s};
                        error_n_s  = ovf_s ? ERR_OVF : ERR_NONE;
                    end
                    CMD_MUL: begin
                        step_s     = !fin_s;
                        complete_s = fin_s;
                        result_n_s = fin_s ? {acc_s, quo_s} : result_r;
                        error_n_s  = fin_s ? ERR_NONE : error_r;
                    end
                    CMD_DIV: begin
                        if (b_zero_s) begin
                            complete_s = 1'b1;
                            result_n_s = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                            error_n_s  = ERR_DIV0;
                        end else begin
                            step_s     = !fin_s;
                            complete_s = fin_s;
                            result_n_s = fin_s ? {{WIDTH{1'b0}}, quo_s} : result_r;
                            error_n_s  = fin_s ? ERR_NONE : error_r;
                        end
                    end
                    CMD_MOD: begin
                        if (b_zero_s) begin
                            complete_s = 1'b1;
                            result_n_s = {{WIDTH{1'b0}}, a_r};
                            error_n_s  = ERR_DIV0;
                        end else begin
                            step_s     = !fin_s;
                            complete_s = fin_s;
                            result_n_s = fin_s ? {{WIDTH{1'b0}}, acc_s} : result_r;
                            error_n_s  = fin_s ? ERR_NONE : error_r;
                        end
                    end
                    default: begin
                        complete_s = 1'b1;
                        result_n_s = {(2*WIDTH){1'b0}};
                        error_n_s  = ERR_INVALID;
                    end
                endcase
                if (complete_s) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_RUN;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Command and operand capture on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_r <= CMD_NOP;
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            cmd_r <= cmd_t'(command);
            a_r   <= input_a;
            b_r   <= input_b;
        end
    end

    // Registered outputs; result/error only move on the completion edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {(2*WIDTH){1'b0}};
            error_r  <= 1'b0;
        end else begin
            busy_r <= (state_n_s == ST_RUN);
            done_r <= complete_s;
            if (complete_s) begin
                result_r <= result_n_s;
                error_r  <= error_n_s;
            end
        end
    end

    seq_muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (accept_s),
        .op   (md_op_of(command)),
        .step (step_s),
        .a    (input_a),
        .b    (input_b),
        .fin  (fin_s),
        .acc  (acc_s),
        .quo  (quo_s)
    );

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign error  = error_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16): vector table plus handshake,
// back-to-back and mid-operation reset sequences.
module tb_seq_alu;

    localparam int W = 16;

    logic           clk;
    logic           rst;
    logic           start;
    logic [3:0]     command;
    logic [W-1:0]   input_a;
    logic [W-1:0]   input_b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           error;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]     cmd;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        logic           err;
        int             lat;
        string          name;
    } vec_t;

    vec_t vecs[17];

    seq_alu #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .command (command),
        .input_a (input_a),
        .input_b (input_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .error   (error)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one command, wait for done (bounded), check latency and outputs.
    task automatic run_vec(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] er, input logic ee, input int lat, input string nm);
        int n;
        logic got;
        @(negedge clk);
        start = 1'b1; command = cmd; input_a = a; input_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, " busy@accept"}, 64'(busy), 64'd1);
        n = 0; got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk); #1;
            n++;
            if (done) got = 1'b1;
        end
        chk({nm, " latency"}, 64'(n), 64'(lat));
        chk({nm, " result"}, 64'(result), 64'(er));
        chk({nm, " error"}, 64'(error), 64'(ee));
        chk({nm, " busy@done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk({nm, " done one cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int dcount;
        int dlat;
        logic got;

        vecs[0]  = '{4'd1, 16'h07FF, 16'h01FF, 32'h000009FE, 1'b0, 1,  "add"};
        vecs[1]  = '{4'd2, 16'h7FFF, 16'hFFFF, 32'h00008000, 1'b1, 1,  "sub_ovf"};
        vecs[2]  = '{4'd2, 16'h0005, 16'h0007, 32'h0000FFFE, 1'b0, 1,  "sub_neg"};
        vecs[3]  = '{4'd1, 16'h7FFF, 16'h0001, 32'h00008000, 1'b1, 1,  "add_ovf"};
        vecs[4]  = '{4'd1, 16'hFFFF, 16'h0001, 32'h00000000, 1'b0, 1,  "add_wrap"};
        vecs[5]  = '{4'd3, 16'h07FF, 16'h01FF, 32'h000FF601, 1'b0, 17, "mul"};
        vecs[6]  = '{4'd3, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 17, "mul_max"};
        vecs[7]  = '{4'd3, 16'h0000, 16'h1234, 32'h00000000, 1'b0, 17, "mul_zero"};
        vecs[8]  = '{4'd4, 16'd1000, 16'd7,    32'd142,      1'b0, 17, "div"};
        vecs[9]  = '{4'd5, 16'd1000, 16'd7,    32'd6,        1'b0, 17, "mod"};
        vecs[10] = '{4'd4, 16'd1000, 16'd0,    32'h0000FFFF, 1'b1, 1,  "div0"};
        vecs[11] = '{4'd5, 16'd1000, 16'd0,    32'h000003E8, 1'b1, 1,  "mod0"};
        vecs[12] = '{4'd9, 16'h0001, 16'h0002, 32'h00000000, 1'b1, 1,  "op9"};
        vecs[13] = '{4'd0, 16'h0003, 16'h0004, 32'h00000000, 1'b0, 1,  "nop"};
        vecs[14] = '{4'd4, 16'hFFFF, 16'h0001, 32'h0000FFFF, 1'b0, 17, "div_by1"};
        vecs[15] = '{4'd15, 16'h0003, 16'h0004, 32'h00000000, 1'b1, 1, "op15"};
        vecs[16] = '{4'd5, 16'h0005, 16'h0009, 32'h00000005, 1'b0, 17, "mod_small"};

        rst = 1'b1; start = 1'b0; command = 4'd0; input_a = '0; input_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset error", 64'(error), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err,
                    vecs[i].lat, vecs[i].name);
        end

        // Starts during a mul are ignored; exactly one done, result held meanwhile.
        @(negedge clk);
        start = 1'b1; command = 4'd3; input_a = 16'd3; input_b = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0; dlat = 0;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk); #1;
            if (done) begin
                dcount++;
                dlat = k;
            end
            if (k == 6) chk("hold result while busy", 64'(result), 64'd5);
            command = 4'd1; input_a = 16'd1; input_b = 16'd1;
            start = (k < 12) && (k % 2 == 0);
        end
        start = 1'b0;
        chk("ignored start done count", 64'(dcount), 64'd1);
        chk("ignored start latency", 64'(dlat), 64'd17);
        chk("ignored start result", 64'(result), 64'd15);
        chk("ignored start idle", 64'(busy), 64'd0);

        // Back-to-back: start raised in the done cycle is accepted at the next edge.
        @(negedge clk);
        start = 1'b1; command = 4'd3; input_a = 16'd7; input_b = 16'd6;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        chk("b2b first done", 64'(got), 64'd1);
        chk("b2b first result", 64'(result), 64'd42);
        start = 1'b1; command = 4'd1; input_a = 16'd2; input_b = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b accepted busy", 64'(busy), 64'd1);
        chk("b2b no done", 64'(done), 64'd0);
        @(posedge clk); #1;
        chk("b2b second done", 64'(done), 64'd1);
        chk("b2b second result", 64'(result), 64'd5);

        // Reset at iteration 8 of a mul abandons it; rst wins over start.
        @(negedge clk);
        start = 1'b1; command = 4'd3; input_a = 16'h07FF; input_b = 16'h01FF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid-op busy before rst", 64'(busy), 64'd1);
        rst = 1'b1; start = 1'b1; command = 4'd1;
        @(posedge clk); #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        chk("rst error", 64'(error), 64'd0);
        rst = 1'b0; start = 1'b0;
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        chk("no activity after rst", 64'(dcount), 64'd0);
        run_vec(4'd1, 16'h07FF, 16'h01FF, 32'h000009FE, 1'b0, 1, "add after rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
